damage_scanner: RTL and testbench
=================================

# damage_scanner

Parametrised per-frame collision scanner and HP tracker for the battle screen. On each frame `start` pulse it walks every bullet slot once, one slot per clock. For each slot it sums colour-qualified damage and heal contributions. It then applies the net result to a saturating player HP register and pulses `complete`. It sits between the bullet/collision logic, which answers per-slot queries through `index`, and the HUD/game-state logic, which consumes `hp`, `dead` and the per-frame totals.

## Interface
Parameters:
- `N_SLOTS`, 8: number of bullet slots scanned per frame (≥2).
- `IDX_W`, 3: width of `index`; must satisfy 2^IDX_W ≥ N_SLOTS.
- `DMG_W`, 8: width of the `damage`, `heal_amt` and `hp` outputs.
- `ATTACK_POWER`, 10: damage added per qualifying hit.
- `HEAL_POWER`, 5: heal added per heal-bullet hit.
- `HP_MAX`, 100: HP value at reset; upper clamp; must be < 2^DMG_W.
- `IFRAME_FRAMES`, 30: invulnerability length in frames (used only with `DMG_IFRAME_EN`).

Ports:
- `clk` in 1: system clock. One clock domain; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame start, sampled synchronously; one-cycle pulse.
- `is_collide` in 1: queried slot overlaps the player.
- `is_render` in 1: queried slot is active.
- `is_move` in 1: player moved this frame.
- `color` in 3: colour of the queried slot.
- `index` out IDX_W: slot currently being queried.
- `busy` out 1: high in SCAN and APPLY.
- `damage` out DMG_W: accumulated damage this frame.
- `heal_amt` out DMG_W: accumulated heal this frame.
- `hp` out DMG_W: current player HP.
- `dead` out 1: sticky; HP reached 0.
- `invuln` out 1: invulnerability window active.
- `complete` out 1: one-cycle pulse when the frame result is applied.

## Operation
- States: IDLE, SCAN, APPLY.
- Reset values: IDLE; `index`=0, `damage`=0, `heal_amt`=0, `busy`=0, `complete`=0, `dead`=0, `invuln`=0, `hp`=HP_MAX, i-frame counter=0.
- IDLE→SCAN on `start`=1, when not `dead`.
  - On that edge: clear `damage`, `heal_amt`, `index`.
  - Otherwise `start` is ignored: when busy, when dead, and in SCAN/APPLY.
- SCAN: each edge samples the inputs for slot `index`. A slot qualifies only if `is_collide && is_render`. By `color`:
  - 0 (white): damage += ATTACK_POWER.
  - 1 (green): heal_amt += HEAL_POWER.
  - 2 (blue): damage += ATTACK_POWER only if `is_move`=1.
  - 3 (orange): damage += ATTACK_POWER only if `is_move`=0.
  - 4–7: ignored.
  - Both accumulators saturate at 2^DMG_W−1.
  - `index` increments after each sample. After the slot N_SLOTS−1 sample: `index` holds N_SLOTS−1 and the state goes to APPLY.
- APPLY, one edge:
  - `hp` ← clamp(`hp` − `damage` + `heal_amt`, 0, HP_MAX), computed in DMG_W+2 signed bits.
  - `dead` ← 1 if the result is 0.
  - `complete`=1; state → IDLE.
- `damage`/`heal_amt` hold their values until the next accepted `start`.

## Timing
- Accepted `start` on edge E0. Slots 0..N_SLOTS−1 are sampled on E1..E(N_SLOTS).
  - Slot inputs must be valid combinationally from `index` before each edge.
- `hp` updates and `complete` rises on edge E(N_SLOTS+1). `complete` falls on the following edge.
- Total latency start→complete: N_SLOTS+1 cycles.
- `busy` is high from after E0 through E(N_SLOTS+1) exclusive, i.e. N_SLOTS+1 cycles.
- Back-to-back: `start` on the same edge `complete` is asserted is ignored; it must arrive at least 1 cycle later.
- Asserting `rst_n`=0 mid-scan immediately forces all reset values; the partial frame is discarded.

## Configuration
- Macro `DMG_IFRAME_EN` defined:
  - APPLY with `damage`≠0 and not `invuln` loads the counter with IFRAME_FRAMES.
  - Each accepted `start` decrements a nonzero counter. `invuln` = counter≠0.
  - While `invuln`, damage contributions are discarded (`damage` stays 0); heals still count.
- Macro not defined: no counter; `invuln` tied 0; IFRAME_FRAMES unused.

## Test plan
- Reset → `hp`=100, `dead`=0, `complete`=0, `index`=0.
- N=8; slots 0 and 3 white hits, slot 5 green, all others miss → `damage`=20, `heal_amt`=5, `hp`=85, `complete` exactly 9 cycles after `start`.
- Slot 2 blue with `is_move`=0 and slot 4 orange with `is_move`=0 → `damage`=10. Repeat with `is_move`=1 → `damage`=10 (blue only).
- `hp`=15, two white hits → `hp`=0, `dead`=1; next `start` ignored (`busy` stays 0). Heal at `hp`=98 with 1 green hit → `hp`=100 (clamped).
- `start` pulse mid-scan is ignored (`index` sequence unchanged). `rst_n` low at `index`=4 → `hp`=100, state IDLE.
- With `DMG_IFRAME_EN` and IFRAME_FRAMES=2: hit frame → `hp`=90, `invuln`=1; next frame's white hit gives `damage`=0; `invuln`=0 after the 2nd subsequent `start`.

Source files
------------

// File: rtl/damage_scanner.sv
// damage_scanner: per-frame bullet slot scan accumulating damage/heal into a saturating HP register.
// Optional invulnerability frames are enabled by defining DMG_IFRAME_EN.
module damage_scanner #(
  parameter int N_SLOTS       = 8,
  parameter int IDX_W         = 3,
  parameter int DMG_W         = 8,
  parameter int ATTACK_POWER  = 10,
  parameter int HEAL_POWER    = 5,
  parameter int HP_MAX        = 100,
  parameter int IFRAME_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_collide,
  input  logic             is_render,
  input  logic             is_move,
  input  logic [2:0]       color,
  output logic [IDX_W-1:0] index,
  output logic             busy,
  output logic [DMG_W-1:0] damage,
  output logic [DMG_W-1:0] heal_amt,
  output logic [DMG_W-1:0] hp,
  output logic             dead,
  output logic             invuln,
  output logic             complete
);
  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SLOTS - 1);
  localparam logic [DMG_W-1:0] SAT = '1;
  state_t state, state_nx;
  logic accept, qual, dmg_hit, heal_hit;
  logic [DMG_W:0] dmg_sum, heal_sum;
  logic signed [DMG_W+1:0] hp_calc;
  logic [DMG_W-1:0] hp_next;
  assign accept   = state == IDLE && start && !dead;
  assign qual     = is_collide && is_render;
  assign heal_hit = qual && color == 3'd1;
  assign dmg_hit  = qual && !invuln &&
                    (color == 3'd0 || (color == 3'd2 && is_move) || (color == 3'd3 && !is_move));
  assign dmg_sum  = {1'b0, damage} + (DMG_W+1)'(ATTACK_POWER);
  assign heal_sum = {1'b0, heal_amt} + (DMG_W+1)'(HEAL_POWER);
  // two guard bits keep the signed intermediate from wrapping before the clamp
  assign hp_calc  = $signed({2'b00, hp}) - $signed({2'b00, damage}) + $signed({2'b00, heal_amt});
  assign hp_next  = hp_calc < 0 ? '0 : hp_calc > HP_MAX ? DMG_W'(HP_MAX) : hp_calc[DMG_W-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (accept ? SCAN : IDLE) :
               state == SCAN ? (index == LAST ? APPLY : SCAN) : IDLE;
  always_comb
    busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      index    <= '0;
      damage   <= '0;
      heal_amt <= '0;
      hp       <= DMG_W'(HP_MAX);
      dead     <= 1'b0;
      complete <= 1'b0;
    end else begin
      complete <= state == APPLY;
      if (accept) begin
        index    <= '0;
        damage   <= '0;
        heal_amt <= '0;
      end
      if (state == SCAN) begin
        if (index != LAST) index <= index + 1'b1;
        if (dmg_hit) damage <= dmg_sum[DMG_W] ? SAT : dmg_sum[DMG_W-1:0];
        if (heal_hit) heal_amt <= heal_sum[DMG_W] ? SAT : heal_sum[DMG_W-1:0];
      end
      if (state == APPLY) begin
        hp <= hp_next;
        if (hp_next == '0) dead <= 1'b1;
      end
    end
`ifdef DMG_IFRAME_EN
  localparam int CNT_W = $clog2(IFRAME_FRAMES + 1);
  logic [CNT_W-1:0] iframe_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) iframe_cnt <= '0;
    else if (state == APPLY && damage != '0 && !invuln) iframe_cnt <= CNT_W'(IFRAME_FRAMES);
    else if (accept && iframe_cnt != '0) iframe_cnt <= iframe_cnt - 1'b1;
  assign invuln = iframe_cnt != '0;
`else
  assign invuln = 1'b0;
`endif
endmodule

// File: tb/tb_damage_scanner.sv
// tb_damage_scanner: directed and random frames checked against a per-frame arithmetic HP model.
module tb_damage_scanner;
  localparam int N = 8;
  logic clk = 0, rst_n = 0, start = 0, is_collide, is_render, is_move = 0;
  logic [2:0] color, index;
  logic busy, dead, invuln, complete;
  logic [7:0] damage, heal_amt, hp;
  bit cl[N], rn[N];
  logic [2:0] co[N];
  int checks = 0, errors = 0, hp_m = 100;
  bit dead_m = 0;

  always #5 clk = ~clk;

  damage_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_collide(is_collide), .is_render(is_render),
    .is_move(is_move), .color(color), .index(index), .busy(busy), .damage(damage),
    .heal_amt(heal_amt), .hp(hp), .dead(dead), .invuln(invuln), .complete(complete)
  );

  always_comb begin
    is_collide = cl[index];
    is_render  = rn[index];
    color      = co[index];
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(output int d, output int h);
    d = 0;
    h = 0;
    for (int i = 0; i < N; i++)
      if (cl[i] && rn[i]) begin
        if (co[i] == 0 || (co[i] == 2 && is_move) || (co[i] == 3 && !is_move)) d += 10;
        else if (co[i] == 1) h += 5;
      end
    if (d > 255) d = 255;
    if (h > 255) h = 255;
  endfunction

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      cl[i] = 0;
      rn[i] = 0;
      co[i] = 0;
    end
  endtask

  task automatic hit(input int s, input int c);
    cl[s] = 1;
    rn[s] = 1;
    co[s] = 3'(c);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 0;
    #1;
    chk("rst_hp", hp, 100);
    chk("rst_dead", dead, 0);
    @(negedge clk) rst_n = 1;
    hp_m = 100;
    dead_m = 0;
  endtask

  task automatic frame(input bit mid_start, input int rst_at);
    int d, h, nhp;
    model(d, h);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    if (dead_m) begin
      chk("ign_busy", busy, 0);
      chk("ign_hp", hp, hp_m);
      return;
    end
    for (int k = 0; k <= N + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= N) begin
        chk("index", index, k < N ? k : N - 1);
        chk("busy", busy, 1);
        chk("cmpl_early", complete, 0);
      end
      if (mid_start && k == 2) start = 1;
      if (mid_start && k == 3) start = 0;
      if (k == rst_at) begin
        #2 rst_n = 0;
        #1;
        chk("mid_rst_hp", hp, 100);
        chk("mid_rst_idx", index, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dmg", damage, 0);
        @(negedge clk) rst_n = 1;
        hp_m = 100;
        dead_m = 0;
        return;
      end
    end
    nhp = hp_m - d + h;
    if (nhp < 0) nhp = 0;
    if (nhp > 100) nhp = 100;
    hp_m = nhp;
    if (nhp == 0) dead_m = 1;
    chk("cmpl", complete, 1);
    chk("busy_end", busy, 0);
    chk("damage", damage, d);
    chk("heal", heal_amt, h);
    chk("hp", hp, hp_m);
    chk("dead", dead, dead_m);
    chk("invuln", invuln, 0);
    @(negedge clk) chk("cmpl_fall", complete, 0);
  endtask

  initial begin
    clr();
    #12;
    chk("reset_hp", hp, 100);
    chk("reset_dead", dead, 0);
    chk("reset_cmpl", complete, 0);
    chk("reset_idx", index, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk) rst_n = 1;
    clr(); hit(0, 0); hit(3, 0); hit(5, 1);
    frame(0, -1);
    clr(); hit(2, 2); hit(4, 3); is_move = 0;
    frame(0, -1);
    is_move = 1;
    frame(0, -1);
    is_move = 0;
    clr(); cl[1] = 1; co[1] = 0; rn[6] = 1; co[6] = 0;
    frame(0, -1);
    clr(); for (int i = 0; i < 5; i++) hit(i, 0);
    frame(0, -1);
    clr(); hit(0, 0); hit(7, 0);
    frame(0, -1);
    frame(0, -1);
    do_reset();
    clr(); hit(1, 0); hit(2, 1);
    frame(0, -1);
    clr(); hit(3, 1); hit(6, 1);
    frame(0, -1);
    clr(); hit(6, 0);
    frame(1, -1);
    clr(); hit(0, 0);
    frame(0, 4);
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) begin
        cl[i] = $urandom_range(0, 2) == 0;
        rn[i] = $urandom_range(0, 3) != 0;
        co[i] = 3'($urandom_range(0, 7));
      end
      is_move = 1'($urandom_range(0, 1));
      if (dead_m && $urandom_range(0, 1) == 1) do_reset();
      frame(f % 7 == 3, -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
